fnd_display_controller: RTL and testbench

//   Downstream consumer of the 8-bit free-running counter. Converts the unsigned

---
 rtl/fnd_display_controller_pkg.sv | 39 +++
 rtl/fnd_display_controller_if.sv | 28 ++
 rtl/fnd_display_controller_bin2bcd_seq.sv | 60 ++++++
 rtl/fnd_display_controller.sv | 83 ++++++++
 tb/tb_fnd_display_controller.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fnd_display_controller_pkg.sv
// Shared constants, converter state type and helpers for the FND display controller.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} for a common-anode display.
package fnd_display_controller_pkg;

  localparam int DIGITS = 4;
  localparam int BCD_W  = 12;

  localparam logic [7:0] FND_BLANK = 8'hFF;
  localparam logic [7:0] FND_FONT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  // Non-decimal nibbles render as blank rather than garbage segments.
  function automatic logic [7:0] font_of(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      return FND_FONT[nib];
    end
    return FND_BLANK;
  endfunction

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_display_controller_if.sv
// Value-in / display-out bundle between the counter, the FND controller and the board pins.
// The controller takes the slave side; the counter/board wiring takes the master side.
interface fnd_display_controller_if
  import fnd_display_controller_pkg::*;
#(
  parameter int VALUE_W = 8
);

  logic [VALUE_W-1:0] i_value;
  logic [DIGITS-1:0]  o_fnd_com;
  logic [7:0]         o_fnd_font;
  logic [BCD_W-1:0]   o_bcd;

  modport master (
    output i_value,
    input  o_fnd_com,
    input  o_fnd_font,
    input  o_bcd
  );

  modport slave (
    input  i_value,
    output o_fnd_com,
    output o_fnd_font,
    output o_bcd
  );

endinterface

// File: rtl/fnd_display_controller_bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per clock, result committed to o_bcd in DONE.
// o_done is high whenever the converter is idle and ready to accept i_start.
module fnd_display_controller_bin2bcd_seq
  import fnd_display_controller_pkg::*;
#(
  parameter int VALUE_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [VALUE_W-1:0] i_bin,
  input  logic               i_start,
  output logic [BCD_W-1:0]   o_bcd,
  output logic               o_done
);

  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VALUE_W - 1);

  conv_state_t        state;
  logic [VALUE_W-1:0] shift_bin;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   bit_cnt;

  assign o_done = (state == ST_IDLE);

  // Scratch only becomes visible on o_bcd in DONE, so partial results never leak out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      shift_bin <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      o_bcd     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            shift_bin <= i_bin;
            scratch   <= '0;
            bit_cnt   <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {scratch, shift_bin} <= {dabble_adjust(scratch), shift_bin} << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_bcd <= scratch;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fnd_display_controller.sv
// Converts the counter value to BCD on change and scans it onto a 4-digit common-anode FND.
// Digit 0 = ones, 1 = tens, 2 = hundreds, 3 = always blank.
module fnd_display_controller
  import fnd_display_controller_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int VALUE_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  fnd_display_controller_if.slave  bus
);

  localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  logic [VALUE_W-1:0] last_value;
  logic               conv_ready;
  logic               conv_start;
  logic [BCD_W-1:0]   bcd;
  logic [PRESC_W-1:0] prescaler;
  logic [1:0]         digit_idx;
  logic [DIGITS-1:0]  com_next;
  logic [7:0]         font_next;

  // A new value is only sampled while idle; later changes are picked up on the next idle cycle.
  assign conv_start = conv_ready && (bus.i_value != last_value);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_value <= '0;
    end else if (conv_start) begin
      last_value <= bus.i_value;
    end
  end

  fnd_display_controller_bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_bin   (bus.i_value),
    .i_start (conv_start),
    .o_bcd   (bcd),
    .o_done  (conv_ready)
  );

  assign bus.o_bcd = bcd;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (prescaler == PRESC_LAST) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    com_next = ~(DIGITS'(1) << digit_idx);
    case (digit_idx)
      2'd0:    font_next = font_of(bcd[3:0]);
      2'd1:    font_next = font_of(bcd[7:4]);
      2'd2:    font_next = font_of(bcd[11:8]);
      default: font_next = FND_BLANK;
    endcase
  end

  // Common and segment lines are registered together so a digit never shows its neighbour's font.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_fnd_com  <= 4'b1110;
      bus.o_fnd_font <= 8'hC0;
    end else begin
      bus.o_fnd_com  <= com_next;
      bus.o_fnd_font <= font_next;
    end
  end

endmodule

// File: tb/tb_fnd_display_controller.sv
// Directed bench for fnd_display_controller with a fast scan (SCAN_DIV=4).
// Table vectors cover conversion latency and per-digit fonts; hand sequences cover races and reset.
module tb_fnd_display_controller;

  localparam int SCAN_DIV = 4;
  localparam int SCAN_BOUND = 4 * SCAN_DIV + 4;

  typedef struct {
    logic [7:0]       value;
    logic [11:0]      exp_bcd;
    logic [3:0][7:0]  exp_font;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fnd_display_controller_if #(.VALUE_W(8)) bus ();

  fnd_display_controller #(
    .SCAN_DIV (SCAN_DIV),
    .VALUE_W  (8)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] value, input logic rst);
    bus.i_value = value;
    reset       = rst;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic waitCom(input logic [3:0] pattern, output bit found);
    found = 1'b0;
    for (int t = 0; t < SCAN_BOUND && !found; t++) begin
      if (bus.o_fnd_com == pattern) found = 1'b1;
      else tick();
    end
    if (!found) checkOutput("com_wait_timeout", {28'd0, bus.o_fnd_com}, {28'd0, pattern});
  endtask

  vec_t        vectors [8];
  logic [11:0] prev_bcd;
  logic [3:0]  prev_com;
  logic [3:0]  pattern;
  logic [11:0] exp;
  bit          found;
  int          changes;
  int          since;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vectors[0] = '{8'd255, 12'h255, {8'hFF, 8'hA4, 8'h92, 8'h92}};
    vectors[1] = '{8'd0,   12'h000, {8'hFF, 8'hC0, 8'hC0, 8'hC0}};
    vectors[2] = '{8'd128, 12'h128, {8'hFF, 8'hF9, 8'hA4, 8'h80}};
    vectors[3] = '{8'd64,  12'h064, {8'hFF, 8'hC0, 8'h82, 8'h99}};
    vectors[4] = '{8'd9,   12'h009, {8'hFF, 8'hC0, 8'hC0, 8'h90}};
    vectors[5] = '{8'd173, 12'h173, {8'hFF, 8'hF9, 8'hF8, 8'hB0}};
    vectors[6] = '{8'd255, 12'h255, {8'hFF, 8'hA4, 8'h92, 8'h92}};
    vectors[7] = '{8'd0,   12'h000, {8'hFF, 8'hC0, 8'hC0, 8'hC0}};

    // Reset with value 0: idle display of "000" and no conversion afterwards
    applyStimulus(8'd0, 1'b1);
    repeat (3) tick();
    checkOutput("reset_com",  {28'd0, bus.o_fnd_com},  32'hE);
    checkOutput("reset_font", {24'd0, bus.o_fnd_font}, 32'hC0);
    checkOutput("reset_bcd",  {20'd0, bus.o_bcd},      32'h0);
    applyStimulus(8'd0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick();
      checkOutput("idle_bcd", {20'd0, bus.o_bcd}, 32'h0);
    end

    // Scan order and period: one-hot-low rotation, one step every SCAN_DIV cycles
    prev_com = bus.o_fnd_com;
    changes  = 0;
    since    = 0;
    for (int t = 0; t < 40 && changes < 5; t++) begin
      tick();
      since++;
      if (bus.o_fnd_com != prev_com) begin
        checkOutput("com_onehot", $countones(~bus.o_fnd_com), 32'd1);
        checkOutput("com_step", {28'd0, bus.o_fnd_com}, {28'd0, prev_com[2:0], prev_com[3]});
        if (changes > 0) checkOutput("com_period", since, SCAN_DIV);
        since    = 0;
        prev_com = bus.o_fnd_com;
        changes++;
      end
    end
    checkOutput("com_changes", changes, 32'd5);

    // Table: exact 9-cycle latency after capture, then every digit's font
    prev_bcd = 12'h000;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i].value, 1'b0);
      repeat (9) tick();
      checkOutput($sformatf("v%0d_bcd_hold", i), {20'd0, bus.o_bcd}, {20'd0, prev_bcd});
      tick();
      checkOutput($sformatf("v%0d_bcd", i), {20'd0, bus.o_bcd}, {20'd0, vectors[i].exp_bcd});
      prev_bcd = vectors[i].exp_bcd;
      tick();
      for (int d = 0; d < 4; d++) begin
        pattern = ~(4'b0001 << d);
        waitCom(pattern, found);
        if (found) begin
          checkOutput($sformatf("v%0d_font_d%0d", i, d), {24'd0, bus.o_fnd_font},
                      {24'd0, vectors[i].exp_font[d]});
        end
      end
    end

    // Value changes mid-conversion: 37 commits first, 200 ten cycles later, nothing else
    applyStimulus(8'd37, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 2) applyStimulus(8'd200, 1'b0);
      if (c < 10)      exp = 12'h000;
      else if (c < 20) exp = 12'h037;
      else             exp = 12'h200;
      checkOutput($sformatf("race_bcd_c%0d", c), {20'd0, bus.o_bcd}, {20'd0, exp});
    end

    // Reset on the 4th shift of 100: outputs reset, then a fresh conversion
    applyStimulus(8'd100, 1'b0);
    repeat (4) tick();
    applyStimulus(8'd100, 1'b1);
    tick();
    checkOutput("midrst_com",  {28'd0, bus.o_fnd_com},  32'hE);
    checkOutput("midrst_font", {24'd0, bus.o_fnd_font}, 32'hC0);
    checkOutput("midrst_bcd",  {20'd0, bus.o_bcd},      32'h0);
    applyStimulus(8'd100, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = (c < 10) ? 12'h000 : 12'h100;
      checkOutput($sformatf("midrst_bcd_c%0d", c), {20'd0, bus.o_bcd}, {20'd0, exp});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
